// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and Hrq/Hlda bus-hold sequencer for the 8237A DMA model.
// Chooses one winning channel, drives one-hot Dack and tracks rotating priority.
module dma_priority_arbiter #(
    parameter int NUM_CH           = 4,
    parameter int DREQ_ACTIVE_LOW  = 0,
    parameter int DACK_ACTIVE_HIGH = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Dreq,
    input  logic              Hlda,
    input  logic [NUM_CH-1:0] Mask,
    input  logic [NUM_CH-1:0] SoftReq,
    input  logic              RotatingPriority,
    input  logic              ControllerDisable,
    input  logic              XferDone,
    output logic              Hrq,
    output logic [NUM_CH-1:0] Dack,
    output logic [1:0]        ActiveCh,
    output logic              ChValid,
    output logic [1:0]        HighestPri
);

    localparam logic [NUM_CH-1:0] DACK_IDLE = (DACK_ACTIVE_HIGH != 0) ? '0 : '1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GRANT,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic [1:0]        ch_q, ch_d;
    logic              valid_q, valid_d;
    logic [1:0]        hp_q, hp_d;

    logic [NUM_CH-1:0] dreq_act;
    logic [NUM_CH-1:0] eff;
    logic              any_req;
    logic [1:0]        win;
    logic              win_found;
    logic [1:0]        idx;
    logic [NUM_CH-1:0] win_oh;

    assign dreq_act = (DREQ_ACTIVE_LOW != 0) ? ~Dreq : Dreq;
    assign eff      = ControllerDisable ? '0 : ((dreq_act & ~Mask) | SoftReq);
    assign any_req  = |eff;

    // Scan from the highest-priority channel upward; 2-bit index wraps mod 4.
    always_comb begin
        win       = hp_q;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = hp_q + k[1:0];
            if (!win_found && eff[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    assign win_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << win;

    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        dack_d  = dack_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        hp_d    = RotatingPriority ? hp_q : '0;

        case (state_q)
            IDLE: begin
                hrq_d = 1'b0;
                if (any_req) begin
                    state_d = REQ;
                    hrq_d   = 1'b1;
                end
            end
            REQ: begin
                hrq_d = 1'b1;
                if (Hlda && any_req) begin
                    state_d = GRANT;
                    dack_d  = (DACK_ACTIVE_HIGH != 0) ? win_oh : ~win_oh;
                    ch_d    = win;
                    valid_d = 1'b1;
                end else if (Hlda) begin
                    state_d = RELEASE;
                    hrq_d   = 1'b0;
                end else if (!any_req) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end
            end
            GRANT: begin
                // Completion takes precedence over a simultaneous Hlda drop.
                if (XferDone) begin
                    state_d = RELEASE;
                    dack_d  = DACK_IDLE;
                    valid_d = 1'b0;
                    hrq_d   = 1'b0;
                    if (RotatingPriority) begin
                        hp_d = ch_q + 2'd1;
                    end
                end else if (!Hlda) begin
                    state_d = IDLE;
                    dack_d  = DACK_IDLE;
                    valid_d = 1'b0;
                    hrq_d   = 1'b0;
                end
            end
            RELEASE: begin
                hrq_d = 1'b0;
                if (!Hlda) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hrq_d   = 1'b0;
                dack_d  = DACK_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= DACK_IDLE;
            ch_q    <= '0;
            valid_q <= 1'b0;
            hp_q    <= '0;
        end else begin
            state_q <= state_d;
            hrq_q   <= hrq_d;
            dack_q  <= dack_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            hp_q    <= hp_d;
        end
    end

    assign Hrq        = hrq_q;
    assign Dack       = dack_q;
    assign ActiveCh   = ch_q;
    assign ChValid    = valid_q;
    assign HighestPri = hp_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Channel arbiter and bus-hold sequencer for the 8237A DMA model. It combines the four Dreq lines, mask bits and software requests into one winning channel. It runs the Hrq/Hlda handshake with the 8086 BFM and drives Dack to the IO devices. The timing/control FSM reports end of service through XferDone. The arbiter owns only channel selection and the hold handshake; it never drives Address, Data or the strobes.

Parameters:
NUM_CH, 4, number of channels; fixed at 4 for the 8237A; priority rotation is modulo NUM_CH
DREQ_ACTIVE_LOW, 0, 1 = Dreq inputs are asserted low (command register bit 6 equivalent)
DACK_ACTIVE_HIGH, 0, 1 = Dack outputs are asserted high (command register bit 7 equivalent)

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-high reset
Dreq  input  4  raw channel DMA requests (polarity per DREQ_ACTIVE_LOW)
Hlda  input  1  hold acknowledge from the CPU/BFM
Mask  input  4  per-channel mask bits; 1 = hardware request ignored
SoftReq  input  4  software request bits; not maskable
RotatingPriority  input  1  0 = fixed priority (channel 0 highest), 1 = rotating
ControllerDisable  input  1  1 = no new service may start
XferDone  input  1  one-cycle pulse: current channel service complete (TC, EOP or single transfer end)
Hrq  output  1  hold request to CPU
Dack  output  4  one-hot channel acknowledge (polarity per DACK_ACTIVE_HIGH)
ActiveCh  output  2  encoded granted channel; valid while ChValid = 1
ChValid  output  1  1 = a channel owns the bus
HighestPri  output  2  channel that currently has highest priority

Behaviour:
- eff[i] = ((Dreq[i] normalised to active-high) & ~Mask[i]) | SoftReq[i], then forced to 0 when ControllerDisable = 1. anyReq = OR of eff.
- All outputs are registered.
- Reset (asynchronous, effective immediately, including mid-service):
  - state = IDLE, Hrq = 0, Dack = all inactive, ActiveCh = 0, ChValid = 0, HighestPri = 0.
- States and transitions:
  - IDLE: Hrq = 0. If anyReq, go to REQ; Hrq = 1 on the same edge, so Hrq rises 1 cycle after the request is sampled.
  - REQ: Hrq = 1.
    - If Hlda = 1 and anyReq: pick winner W, go to GRANT. On that edge Dack[W] goes active, ActiveCh = W, ChValid = 1.
    - If Hlda = 1 and anyReq = 0: go to RELEASE with Hrq = 0.
    - If Hlda = 0 and anyReq = 0: Hrq = 0, go to IDLE.
  - GRANT: winner is locked; new or higher-priority requests do not preempt; ControllerDisable does not abort.
    - On XferDone: Dack inactive, ChValid = 0, Hrq = 0 on the same edge, go to RELEASE. If RotatingPriority = 1, HighestPri = (W+1) mod 4.
    - If Hlda drops to 0 before XferDone: abort. Dack inactive, ChValid = 0, Hrq = 0, go to IDLE; no rotation.
  - RELEASE: Hrq = 0 for at least 1 cycle. Go to IDLE once Hlda = 0.
  - A still-pending request therefore produces a fresh Hrq, at the earliest 2 cycles after Dack drops.
- Winner selection:
  - Scan channels HighestPri, HighestPri+1, … (mod 4); first channel with eff = 1 wins.
  - While RotatingPriority = 0, HighestPri is forced to 0 every cycle, which gives fixed priority 0 > 1 > 2 > 3.
- XferDone outside GRANT is ignored.
- Dack is never multi-hot; at most one bit is active in any cycle.
- Dack is active only in GRANT.

Test Plan:
- Reset values: assert Reset mid-GRANT on channel 2 → Hrq = 0, Dack inactive (4'b1111 with defaults), ChValid = 0, HighestPri = 0 without waiting for a clock edge.
- Fixed priority: Dreq = 4'b1010, Mask = 0 → Hrq next cycle; Hlda = 1 → Dack = 4'b1101 (channel 1), ActiveCh = 1. XferDone → Dack = 4'b1111, Hrq = 0. Drop Hlda → Hrq again, then channel 3 is granted.
- Rotating priority: RotatingPriority = 1, Dreq = 4'b1111. Grants come in order 0, 1, 2, 3, 0; HighestPri after each XferDone is 1, 2, 3, 0.
- Mask and software request: Dreq = 4'b0001, Mask = 4'b0001 → Hrq stays 0. SoftReq = 4'b0100 → channel 2 granted.
- Request withdrawn in REQ: Dreq pulse on channel 0 drops before Hlda → Hrq falls, state returns to IDLE, no Dack. Hlda arriving later with no request → no Dack, Hrq held 0 until Hlda = 0.
- No preemption and Hlda abort: channel 3 in GRANT, Dreq[0] rises → Dack stays on channel 3. Hlda dropped → Dack and Hrq go inactive next edge, HighestPri unchanged.
